// File: rtl/glyph_memory.sv
// Glyph bitmap store: NUM_GLYPHS x GLYPH_H x GLYPH_W pixel flops with a 2-stage
// read pipeline, a direct single-pixel write port and a serial glyph loader.
module glyph_memory #(
    parameter int                 GLYPH_W    = 4,
    parameter int                 GLYPH_H    = 5,
    parameter int                 NUM_GLYPHS = 16,
    parameter int                 BLANK_COL0 = 1,
    parameter logic [GLYPH_W-1:0] RESET_ROW  = GLYPH_W'(4'b1010)
) (
    input  logic                          i_clock,
    input  logic                          i_rst_n,
    input  logic                          i_rd_en,
    input  logic [$clog2(NUM_GLYPHS)-1:0] i_rd_glyph,
    input  logic [2:0]                    i_rd_x,
    input  logic [2:0]                    i_rd_y,
    output logic                          o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_GLYPHS)-1:0] i_wr_glyph,
    input  logic [2:0]                    i_wr_x,
    input  logic [2:0]                    i_wr_y,
    input  logic                          i_wr_data,
    input  logic                          i_load_start,
    input  logic [$clog2(NUM_GLYPHS)-1:0] i_load_glyph,
    input  logic                          i_load_abort,
    input  logic                          i_load_valid,
    input  logic                          i_load_data,
    output logic                          o_load_ready,
    output logic                          o_busy,
    output logic                          o_load_done
);
    localparam int GB = $clog2(NUM_GLYPHS);
    localparam int X0 = (BLANK_COL0 != 0) ? 1 : 0;  // first stored column
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    logic [NUM_GLYPHS-1:0][GLYPH_H-1:0][GLYPH_W-1:0] w_mem;

    logic [0:0]    r_state;
    logic [GB-1:0] r_lg;
    logic [2:0]    r_lx, r_ly;
    logic          r_done;

    logic          w_busy, w_consume, w_last, w_load_we, w_dir_we, w_we, w_wd;
    logic [GB-1:0] w_wg;
    logic [2:0]    w_wx, w_wy;

    function automatic logic f_in_range(input logic [2:0] x, input logic [2:0] y);
        return (int'(x) >= X0) && (int'(x) < GLYPH_W) && (int'(y) < GLYPH_H);
    endfunction

    // Loader and direct port are mutually exclusive (direct writes need !busy),
    // so they share a single write port into the array.
    assign w_busy    = (r_state == S_LOAD);
    assign w_consume = w_busy && i_load_valid && !i_load_abort;
    assign w_last    = (r_lx == 3'(GLYPH_W-1)) && (r_ly == 3'(GLYPH_H-1));
    assign w_load_we = w_consume && (int'(r_lx) >= X0);
    assign w_dir_we  = i_wr_en && !w_busy && f_in_range(i_wr_x, i_wr_y);
    assign w_we      = w_load_we || w_dir_we;
    assign w_wg      = w_busy ? r_lg : i_wr_glyph;
    assign w_wx      = w_busy ? r_lx : i_wr_x;
    assign w_wy      = w_busy ? r_ly : i_wr_y;
    assign w_wd      = w_busy ? i_load_data : i_wr_data;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_lg    <= '0;
            r_lx    <= '0;
            r_ly    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_load_start) begin
                    r_state <= S_LOAD;
                    r_lg    <= i_load_glyph;
                    r_lx    <= '0;
                    r_ly    <= '0;
                end
            end else if (i_load_abort) begin
                r_state <= S_IDLE;
            end else if (i_load_valid) begin
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end else if (r_lx == 3'(GLYPH_W-1)) begin
                    r_lx <= '0;
                    r_ly <= r_ly + 3'd1;
                end else begin
                    r_lx <= r_lx + 3'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_glyph
        for (genvar y = 0; y < GLYPH_H; y++) begin : g_row
            for (genvar x = 0; x < GLYPH_W; x++) begin : g_col
                if (x < X0) begin : g_blank
                    assign w_mem[g][y][x] = 1'b0;
                end else begin : g_flop
                    logic r_bit;
                    always_ff @(posedge i_clock or negedge i_rst_n) begin
                        if (!i_rst_n)
                            r_bit <= RESET_ROW[x];
                        else if (w_we && w_wg == GB'(g) && w_wy == 3'(y) && w_wx == 3'(x))
                            r_bit <= w_wd;
                    end
                    assign w_mem[g][y][x] = r_bit;
                end
            end
        end
    end

    // Stage 1 samples the array before this edge's write, giving read-before-write.
    logic [GLYPH_W-1:0] w_row, r_row;
    logic [2:0]         r_x;
    logic               r_v1, w_pix, r_rd_data, r_rd_valid;

    always_comb begin
        w_row = '0;
        for (int y = 0; y < GLYPH_H; y++)
            if (i_rd_y == 3'(y)) w_row = w_mem[i_rd_glyph][y];
    end

    always_comb begin
        w_pix = 1'b0;
        for (int x = 0; x < GLYPH_W; x++)
            if (r_x == 3'(x) && x >= X0) w_pix = r_row[x];
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1       <= 1'b0;
            r_row      <= '0;
            r_x        <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 1'b0;
        end else begin
            r_v1       <= i_rd_en;
            r_rd_valid <= r_v1;
            if (i_rd_en) begin
                r_row <= w_row;
                r_x   <= i_rd_x;
            end
            if (r_v1) r_rd_data <= w_pix;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_busy       = w_busy;
    assign o_load_ready = w_busy;
    assign o_load_done  = r_done;
endmodule

// File: tb/tb_glyph_memory.sv
// Scoreboard bench for glyph_memory: stimulus pushes expected read results from a
// pixel-array reference model; a negedge monitor pops and compares.
module tb_glyph_memory;
    localparam int W = 4, H = 5, N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       rd_en, wr_en, wr_data, load_start, load_abort, load_valid, load_data;
    logic [3:0] rd_glyph, wr_glyph, load_glyph;
    logic [2:0] rd_x, rd_y, wr_x, wr_y;
    logic       rd_data, rd_valid, load_ready, busy, load_done;

    glyph_memory #(.GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(N), .BLANK_COL0(1),
                   .RESET_ROW(4'b1010)) dut (
        .i_clock(clk), .i_rst_n(rst_n),
        .i_rd_en(rd_en), .i_rd_glyph(rd_glyph), .i_rd_x(rd_x), .i_rd_y(rd_y),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_wr_en(wr_en), .i_wr_glyph(wr_glyph), .i_wr_x(wr_x), .i_wr_y(wr_y),
        .i_wr_data(wr_data),
        .i_load_start(load_start), .i_load_glyph(load_glyph), .i_load_abort(load_abort),
        .i_load_valid(load_valid), .i_load_data(load_data), .o_load_ready(load_ready),
        .o_busy(busy), .o_load_done(load_done)
    );

    typedef struct { int due; bit exp; } rd_t;
    rd_t q[$];
    bit  model [N][8][8];
    int  cyc = 0, n_chk = 0, n_pass = 0;
    bit  m_busy = 0, m_busy_vis = 0, last_data = 0;
    int  m_k = 0, m_g = 0, done_due = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask

    function automatic bit ref_rd(input int g, input int x, input int y);
        if (x >= 1 && x < W && y < H) return model[g][y][x];
        return 1'b0;
    endfunction

    task automatic model_reset();
        logic [3:0] rr = 4'b1010;
        for (int g = 0; g < N; g++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    model[g][y][x] = (x >= 1 && x < W && y < H) ? rr[x] : 1'b0;
    endtask

    task automatic clr();
        rd_en = 0; wr_en = 0; wr_data = 0; load_start = 0; load_abort = 0;
        load_valid = 0; load_data = 0;
        rd_glyph = 0; wr_glyph = 0; load_glyph = 0; rd_x = 0; rd_y = 0; wr_x = 0; wr_y = 0;
    endtask

    task automatic rd(input int g, input int x, input int y);
        rd_en = 1; rd_glyph = 4'(g); rd_x = 3'(x); rd_y = 3'(y);
    endtask

    // Apply the spec's rules for one clock, then advance past the edge.
    task automatic cycle();
        if (rd_en) q.push_back('{cyc + 2, ref_rd(rd_glyph, rd_x, rd_y)});
        if (wr_en && !m_busy && wr_x >= 1 && wr_x < W && wr_y < H)
            model[wr_glyph][wr_y][wr_x] = wr_data;
        if (m_busy) begin
            if (load_abort) m_busy = 0;
            else if (load_valid) begin
                if (m_k % W != 0) model[m_g][m_k / W][m_k % W] = load_data;
                m_k++;
                if (m_k == W * H) begin m_busy = 0; done_due = cyc + 1; end
            end
        end else if (load_start) begin
            m_busy = 1; m_k = 0; m_g = load_glyph;
        end
        @(posedge clk); #1;
        m_busy_vis = m_busy;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic read_glyph(input int g);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin clr(); rd(g, x, y); cycle(); end
        idle(3);
    endtask

    task automatic do_reset();
        rst_n = 0; #1;
        check("rst_busy", busy, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        q.delete(); model_reset();
        m_busy = 0; m_busy_vis = 0; done_due = -1; last_data = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    always @(negedge clk) if (rst_n) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, q[0].exp);
            last_data = q[0].exp;
            void'(q.pop_front());
        end else begin
            check("rd_valid_idle", rd_valid, 0);
            check("rd_data_hold", rd_data, last_data);
        end
        check("busy", busy, m_busy_vis);
        check("load_ready", load_ready, m_busy_vis);
        check("load_done", load_done, cyc == done_due);
    end

    initial begin
        clr();
        #2;
        do_reset();
        idle(2);

        // reset pattern on glyph 3 row 2, column 0 blank
        for (int x = 0; x < W; x++) begin clr(); rd(3, x, 2); cycle(); end
        idle(3);

        // direct write with same-cycle and following read, then blank-column write
        clr(); rd(5, 2, 4); wr_en = 1; wr_glyph = 5; wr_x = 2; wr_y = 4; wr_data = 1; cycle();
        clr(); rd(5, 2, 4); cycle();
        clr(); wr_en = 1; wr_glyph = 5; wr_x = 0; wr_y = 4; wr_data = 1; cycle();
        clr(); rd(5, 0, 4); cycle();
        idle(3);

        // serial load of glyph 7 with all ones and valid gaps
        clr(); load_start = 1; load_glyph = 7; cycle();
        for (int i = 0; i < W * H; i++) begin
            clr(); load_valid = 1; load_data = 1; cycle();
            if (i % 3 == 1) idle(1);
        end
        idle(2);
        read_glyph(7);

        // abort after 6 zero bits on glyph 2
        clr(); load_start = 1; load_glyph = 2; cycle();
        for (int i = 0; i < 6; i++) begin clr(); load_valid = 1; load_data = 0; cycle(); end
        clr(); load_abort = 1; cycle();
        idle(2);
        read_glyph(2);

        // 8 back-to-back reads, including out-of-range x and y
        for (int i = 0; i < 8; i++) begin
            clr(); rd(i, i % 5, (i == 4) ? 6 : i % 5); cycle();
        end
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            clr();
            rd_en = 1'($urandom_range(0, 1));
            rd_glyph = 4'($urandom); rd_x = 3'($urandom); rd_y = 3'($urandom);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_glyph = 4'($urandom); wr_x = 3'($urandom); wr_y = 3'($urandom);
            wr_data = 1'($urandom);
            load_start = ($urandom_range(0, 15) == 0);
            load_glyph = 4'($urandom);
            load_abort = ($urandom_range(0, 39) == 0);
            load_valid = 1'($urandom_range(0, 1));
            load_data = 1'($urandom);
            cycle();
        end
        clr(); load_abort = 1; cycle();
        idle(3);

        // reset in the middle of a load
        clr(); load_start = 1; load_glyph = 9; cycle();
        for (int i = 0; i < 10; i++) begin
            clr(); load_valid = 1; load_data = 1'($urandom); cycle();
        end
        clr();
        do_reset();
        idle(2);
        read_glyph(9);

        idle(4);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/glyph_memory.md
GLYPH_MEMORY -- requirements
Module: glyph_memory

Interface
REQ-001 SHALL have parameter GLYPH_W, default 4, meaning glyph columns per row (2..8).
REQ-002 SHALL have parameter GLYPH_H, default 5, meaning glyph rows (1..8).
REQ-003 SHALL have parameter NUM_GLYPHS, default 16, meaning stored glyph count (power of 2, 2..64).
REQ-004 SHALL have parameter BLANK_COL0, default 1, meaning column 0 is hard-wired blank (reads 0, never stored).
REQ-005 SHALL have parameter RESET_ROW, default GLYPH_W'b1010, meaning row pattern loaded into every row of every glyph at reset.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports rd_en / rd_glyph / rd_x / rd_y  input  1 / log2(NUM_GLYPHS) / 3 / 3  read request, glyph index, column, row.
REQ-009 SHALL have ports rd_data / rd_valid  output  1 / 1  read pixel and its qualifier.
REQ-010 SHALL have ports wr_en / wr_glyph / wr_x / wr_y / wr_data  input  1 / log2(NUM_GLYPHS) / 3 / 3 / 1  direct single-pixel write.
REQ-011 SHALL have ports load_start / load_glyph / load_abort  input  1 / log2(NUM_GLYPHS) / 1  serial glyph-load command.
REQ-012 SHALL have ports load_valid / load_data  input  1 / 1, and load_ready  output  1: serial bit handshake.
REQ-013 SHALL have ports busy / load_done  output  1 / 1  load in progress; one-cycle completion pulse.

Function
REQ-014 SHALL store NUM_GLYPHS x GLYPH_H x GLYPH_W bits in flops; with BLANK_COL0=1 column 0 is not stored.
REQ-015 Read SHALL be a 2-stage pipeline: cycle N rd_en captures glyph row; cycle N+1 column select; rd_data and rd_valid valid in cycle N+2.
REQ-016 Reads SHALL be accepted every cycle (back-to-back); rd_valid SHALL be 0 in any cycle whose request had rd_en=0; rd_data holds its previous value when rd_valid=0.
REQ-017 Read with rd_x>=GLYPH_W, rd_y>=GLYPH_H, or rd_x=0 when BLANK_COL0=1 SHALL return rd_data=0 with rd_valid=1.
REQ-018 Read and write to the same pixel in the same cycle SHALL return the pre-write value (read-before-write).
REQ-019 Direct write SHALL update the pixel at the clock edge when wr_en=1, busy=0, coordinates in range, and not (wr_x=0 with BLANK_COL0=1); otherwise ignored silently.
REQ-020 Load FSM SHALL have states IDLE and LOAD; busy=1 and load_ready=1 exactly in LOAD.
REQ-021 IDLE->LOAD on load_start=1; load_glyph latched; bit counter cleared to 0.
REQ-022 In LOAD, each cycle with load_valid=1 SHALL consume one bit, row-major order (y=0 x=0 first, x increments, wraps to x=0 at GLYPH_W with y+1).
REQ-023 With BLANK_COL0=1, column-0 bits SHALL be consumed but discarded; total bits per load always GLYPH_W*GLYPH_H.
REQ-024 On consumption of the last bit (x=GLYPH_W-1, y=GLYPH_H-1) FSM SHALL return to IDLE and assert load_done for exactly the following cycle.
REQ-025 load_abort=1 in LOAD SHALL return to IDLE next cycle without load_done; bits already written remain; an abort in the same cycle as the last bit SHALL take priority (last bit not written, no load_done).
REQ-026 load_start while in LOAD SHALL be ignored; load_start and load_abort together in IDLE SHALL start a load.
REQ-027 Reads SHALL remain fully operational during LOAD and observe bits as written.

Reset
REQ-028 rst_n=0 SHALL asynchronously set every stored row of every glyph to RESET_ROW (column 0 excluded when BLANK_COL0=1), FSM to IDLE, counters to 0.
REQ-029 During and after reset until the first new read result: rd_data=0, rd_valid=0, busy=0, load_ready=0, load_done=0; pipeline contents discarded.
REQ-030 Reset asserted mid-load SHALL abandon the load with no load_done and memory at reset values.

Verification
REQ-031 Reset defaults: release rst_n, read glyph 3 x=1..3 y=2 -> rd_data 1,0,1 with rd_valid two cycles after each rd_en; x=0 -> 0.
REQ-032 Direct write: wr glyph 5 x=2 y=4 data 1, read same next cycle -> 1; same-cycle read -> old value 0; write x=0 -> no effect, reads 0.
REQ-033 Serial load: load_start glyph 7, feed 20 bits all 1 with load_valid gaps -> load_done one cycle after 20th bit; glyph 7 reads 1 everywhere except column 0.
REQ-034 Abort: start load glyph 2, feed 6 bits of 0, assert load_abort -> busy falls next cycle, no load_done; row 0 and row 1 x=1 read 0, rest RESET_ROW.
REQ-035 Pipeline: rd_en high 8 consecutive cycles over varied coordinates -> 8 consecutive rd_valid cycles with matching data; out-of-range y=6 -> 0.
REQ-036 Reset mid-load: assert rst_n=0 after 10 load bits -> busy=0 immediately, glyph back to RESET_ROW, no load_done.
